mult_host_driver: RTL

- Host-side initiator for the nibble-serial multiplier port.
- Takes two 8-bit operands and sends them as four 4-bit nibbles on a data/valid strobe interface. Each valid pulse is held long enough to pass the DUT-side debouncer and edge detector.
- Then drives the byte-select toggle low and high, samples the 8-bit result bus each time, and assembles the 16-bit product.
- Used as the on-board/bench master for the multiplier tile.

---
 rtl/mult_host_driver_if.sv | 33 +++
 rtl/mult_host_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_host_driver_if.sv
// ---------------------------------------------------------------------------
// mult_host_driver_if
//   Pin-level bus between the host-side driver and the nibble-serial
//   multiplier tile.
//
//   dut_data   [3:0]  nibble presented to the tile data pins
//   dut_valid         strobe; one long pulse per nibble
//   dut_toggle        byte select for the result bus (0 = low, 1 = high)
//   dut_in     [7:0]  result byte returned by the tile
//
//   master : the driver (drives data/valid/toggle, reads dut_in)
//   slave  : the multiplier tile (reads data/valid/toggle, drives dut_in)
// ---------------------------------------------------------------------------
interface mult_host_driver_if;
  logic [3:0] dut_data;
  logic       dut_valid;
  logic       dut_toggle;
  logic [7:0] dut_in;

  modport master (
    output dut_data,
    output dut_valid,
    output dut_toggle,
    input  dut_in
  );

  modport slave (
    input  dut_data,
    input  dut_valid,
    input  dut_toggle,
    output dut_in
  );
endinterface

// File: rtl/mult_host_driver.sv
// ---------------------------------------------------------------------------
// mult_host_driver
//   Host-side initiator for the nibble-serial multiplier tile. Sends two
//   8-bit operands as four nibbles (op_a hi, op_a lo, op_b hi, op_b lo) with
//   one long valid pulse each, then reads the 16-bit product back as two
//   bytes using the byte-select toggle.
//
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   start          transaction request, only looked at while idle
//   op_a, op_b     operands, captured when start is accepted
//   busy           high from the cycle after acceptance through the done cycle
//   done           one-cycle pulse when result is updated
//   result [15:0]  {high byte, low byte} as read from the tile
//   bus            master side of mult_host_driver_if
// ---------------------------------------------------------------------------
module mult_host_driver #(
  parameter int SETTLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1536,
  parameter int GAP_CYCLES    = 1536,
  parameter int CNT_W         = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              op_a,
  input  logic [7:0]              op_b,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             result,
  mult_host_driver_if.master      bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_HIGH    = 3'd2,
    ST_LOW     = 3'd3,
    ST_READ_LO = 3'd4,
    ST_READ_HI = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Terminal counts of the shared phase counter; a phase ends when the
  // counter reaches its parameter minus one.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  // Nibbles still to be sent after the one currently on dut_data.
  logic [11:0]      pend_r;
  logic [7:0]       res_lo_r;

  logic             busy_r;
  logic             done_r;
  logic [15:0]      result_r;
  logic [3:0]       data_r;
  logic             valid_r;
  logic             toggle_r;

  logic             settle_end_s;
  logic             hold_end_s;
  logic             gap_end_s;
  logic             load_s;
  logic             advance_s;
  logic             cap_lo_s;
  logic             cap_hi_s;
  logic             busy_s;
  logic             valid_s;
  logic             toggle_s;
  logic             done_s;

  assign settle_end_s = (cnt_r == SETTLE_LAST);
  assign hold_end_s   = (cnt_r == HOLD_LAST);
  assign gap_end_s    = (cnt_r == GAP_LAST);

  // Next-state decode plus the one-cycle datapath strobes and the values
  // the output registers take at the coming edge.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    cap_lo_s     = 1'b0;
    cap_hi_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_SETUP;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (settle_end_s) begin
          next_state_s = ST_HIGH;
        end else begin
          next_state_s = ST_SETUP;
        end
      end
      ST_HIGH: begin
        if (hold_end_s) begin
          next_state_s = ST_LOW;
        end else begin
          next_state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (gap_end_s) begin
          if (idx_r == 2'd3) begin
            next_state_s = ST_READ_LO;
          end else begin
            next_state_s = ST_SETUP;
            advance_s    = 1'b1;
          end
        end else begin
          next_state_s = ST_LOW;
        end
      end
      ST_READ_LO: begin
        if (settle_end_s) begin
          next_state_s = ST_READ_HI;
          cap_lo_s     = 1'b1;
        end else begin
          next_state_s = ST_READ_LO;
        end
      end
      ST_READ_HI: begin
        if (settle_end_s) begin
          next_state_s = ST_DONE;
          cap_hi_s     = 1'b1;
        end else begin
          next_state_s = ST_READ_HI;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the
    // state they belong to.
    busy_s   = (next_state_s != ST_IDLE);
    valid_s  = (next_state_s == ST_HIGH);
    toggle_s = (next_state_s == ST_READ_HI);
    done_s   = (next_state_s == ST_DONE);
  end

  // State register and phase counter; the counter restarts on every state
  // entry and stays parked at zero while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if ((next_state_s != state_r) || (state_r == ST_IDLE)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Operand shifting, nibble index, result capture and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r    <= 2'd0;
      pend_r   <= 12'h000;
      res_lo_r <= 8'h00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 16'h0000;
      data_r   <= 4'h0;
      valid_r  <= 1'b0;
      toggle_r <= 1'b0;
    end else begin
      if (load_s) begin
        idx_r  <= 2'd0;
        data_r <= op_a[7:4];
        pend_r <= {op_a[3:0], op_b};
      end else if (advance_s) begin
        idx_r  <= idx_r + 2'd1;
        data_r <= pend_r[11:8];
        pend_r <= {pend_r[7:0], 4'h0};
      end else begin
        idx_r  <= idx_r;
        data_r <= data_r;
        pend_r <= pend_r;
      end

      if (cap_lo_s) begin
        res_lo_r <= bus.dut_in;
      end else begin
        res_lo_r <= res_lo_r;
      end

      // The high byte goes straight into result together with the stored
      // low byte, so result changes exactly on the edge that raises done.
      if (cap_hi_s) begin
        result_r <= {bus.dut_in, res_lo_r};
      end else begin
        result_r <= result_r;
      end

      busy_r   <= busy_s;
      done_r   <= done_s;
      valid_r  <= valid_s;
      toggle_r <= toggle_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign result         = result_r;
  assign bus.dut_data   = data_r;
  assign bus.dut_valid  = valid_r;
  assign bus.dut_toggle = toggle_r;

endmodule
